// File: rtl/wb_gpio_bank.sv
// Wishbone-slave GPIO bank: per-pad output/enable registers, synchronised inputs,
// edge-detect status with W1C clear, and status folded onto NUM_IRQ interrupt lines.
module wb_gpio_bank #(
  parameter int          NUM_IO      = 38,
  parameter int          NUM_IRQ     = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic [31:0]        wbs_dat_o,
  output logic               wbs_ack_o,
  input  logic [NUM_IO-1:0]  io_in,
  output logic [NUM_IO-1:0]  io_out,
  output logic [NUM_IO-1:0]  io_oeb,
  output logic [NUM_IRQ-1:0] user_irq
);
  localparam int NB = (NUM_IO + 31) / 32;

  logic [NUM_IO-1:0]  out_q, out_d, oeb_q, oeb_d, ien_q, ien_d;
  logic [NUM_IO-1:0]  rise_q, rise_d, stat_q, stat_d;
  logic [NUM_IO-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_IO-1:0]  prev_q;
  logic               ack_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               wr_valid_q;
  logic [2:0]         wr_bank_q, wr_reg_q;
  logic [3:0]         wr_sel_q;
  logic [31:0]        wr_dat_q;
  logic [NUM_IRQ-1:0] irq_q, irq_d;

  logic               base_hit, req, req_ok, wr_en;
  logic [2:0]         req_bank, req_reg;
  logic [NUM_IO-1:0]  rd_vec, wr_mask, wr_bits, sync_w, evt, stat_clr;
  logic [NB*32-1:0]   rd_pad;

  assign base_hit = wbs_adr_i[31:8] == BASE_ADDR[31:8];
  assign req      = wbs_cyc_i & wbs_stb_i & base_hit & ~ack_q;
  assign req_bank = wbs_adr_i[7:5];
  assign req_reg  = wbs_adr_i[4:2];
  assign req_ok   = (wbs_adr_i[1:0] == 2'b00) && (int'(req_bank) < NB) && (req_reg <= 3'd5);
  assign sync_w   = sync_q[SYNC_STAGES-1];

  always_comb begin
    rd_vec = '0;
    case (req_reg)
      3'd0:    rd_vec = out_q;
      3'd1:    rd_vec = oeb_q;
      3'd2:    rd_vec = sync_w;
      3'd3:    rd_vec = ien_q;
      3'd4:    rd_vec = rise_q;
      3'd5:    rd_vec = stat_q;
      default: rd_vec = '0;
    endcase
  end

  // Flatten pads into 32-bit bank words; bits beyond NUM_IO read as zero.
  for (genvar gi = 0; gi < NB * 32; gi++) begin : g_rd
    if (gi < NUM_IO) begin : g_pad
      assign rd_pad[gi] = rd_vec[gi];
    end else begin : g_zero
      assign rd_pad[gi] = 1'b0;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (req && !wbs_we_i && req_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (int'(req_bank) == b) rdata_d = rd_pad[b*32 +: 32];
      end
    end
  end

  // Write fields are captured at the request and applied at the end of the ack cycle.
  assign wr_en = ack_q & wr_valid_q;

  for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_wr
    assign wr_mask[gi] = wr_en && (wr_bank_q == 3'(gi / 32)) && wr_sel_q[(gi % 32) / 8];
    assign wr_bits[gi] = wr_dat_q[gi % 32];
  end

  assign evt      = (rise_q & sync_w & ~prev_q) | (~rise_q & ~sync_w & prev_q);
  assign stat_clr = (wr_reg_q == 3'd5) ? (wr_bits & wr_mask) : '0;

  always_comb begin
    out_d  = out_q;
    oeb_d  = oeb_q;
    ien_d  = ien_q;
    rise_d = rise_q;
    case (wr_reg_q)
      3'd0:    out_d  = (out_q  & ~wr_mask) | (wr_bits & wr_mask);
      3'd1:    oeb_d  = (oeb_q  & ~wr_mask) | (wr_bits & wr_mask);
      3'd3:    ien_d  = (ien_q  & ~wr_mask) | (wr_bits & wr_mask);
      3'd4:    rise_d = (rise_q & ~wr_mask) | (wr_bits & wr_mask);
      default: ;
    endcase
    // A fresh event on the same bit overrides the clear.
    stat_d = (stat_q & ~stat_clr) | (evt & ien_q);
  end

  function automatic logic [NUM_IO-1:0] irq_mask(input int line);
    irq_mask = '0;
    for (int p = 0; p < NUM_IO; p++) begin
      if (p % NUM_IRQ == line) irq_mask[p] = 1'b1;
    end
  endfunction

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irq
    assign irq_d[gi] = |(stat_q & irq_mask(gi));
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      out_q      <= '0;
      oeb_q      <= '1;
      ien_q      <= '0;
      rise_q     <= '0;
      stat_q     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q     <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_bank_q  <= '0;
      wr_reg_q   <= '0;
      wr_sel_q   <= '0;
      wr_dat_q   <= '0;
      irq_q      <= '0;
    end else begin
      out_q      <= out_d;
      oeb_q      <= oeb_d;
      ien_q      <= ien_d;
      rise_q     <= rise_d;
      stat_q     <= stat_d;
      sync_q[0]  <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q     <= sync_w;
      ack_q      <= req;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      if (req) begin
        wr_valid_q <= req_ok & wbs_we_i;
        wr_bank_q  <= req_bank;
        wr_reg_q   <= req_reg;
        wr_sel_q   <= wbs_sel_i;
        wr_dat_q   <= wbs_dat_i;
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdata_q;
  assign io_out    = out_q;
  assign io_oeb    = oeb_q;
  assign user_irq  = irq_q;
endmodule

// File: tb/tb_wb_gpio_bank.sv
// Directed and randomised bench for wb_gpio_bank against a register-map reference model.
module tb_wb_gpio_bank;
  localparam int          NUM_IO  = 38;
  localparam int          NUM_IRQ = 3;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [63:0] PADMASK = (64'd1 << NUM_IO) - 64'd1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]         sel = '0;
  logic [31:0]        adr = '0, dat_i = '0;
  logic [31:0]        dat_o;
  logic               ack;
  logic [NUM_IO-1:0]  io_in = '0;
  logic [NUM_IO-1:0]  io_out, io_oeb;
  logic [NUM_IRQ-1:0] irq;

  int vectors = 0;
  int miscompares = 0;

  // Model: index 0 OUT, 1 OEB, 3 IEN, 4 RISE, 5 STAT (IN comes from io_in).
  logic [63:0] m_reg [6];

  wb_gpio_bank #(
    .NUM_IO(NUM_IO), .NUM_IRQ(NUM_IRQ), .BASE_ADDR(BASE), .SYNC_STAGES(2)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .user_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_reg[i] = '0;
    m_reg[1] = PADMASK;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int b, r;
    logic [31:0] m32;
    logic [63:0] m, dv;
    b = int'(a[7:5]);
    r = int'(a[4:2]);
    if (a[31:8] != BASE[31:8] || a[1:0] != 2'b00 || b >= 2 || r > 5) return;
    m32 = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    m  = (64'(m32) << (32 * b)) & PADMASK;
    dv = 64'(d) << (32 * b);
    if (r == 5) m_reg[5] = m_reg[5] & ~(dv & m);
    else if (r != 2) m_reg[r] = (m_reg[r] & ~m) | (dv & m);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int b, r;
    logic [63:0] v;
    b = int'(a[7:5]);
    r = int'(a[4:2]);
    if (a[1:0] != 2'b00 || b >= 2 || r > 5) return 32'h0;
    v = (r == 2) ? 64'(io_in) : m_reg[r];
    v = v >> (32 * b);
    return v[31:0];
  endfunction

  task automatic model_event(input logic [63:0] old_v, input logic [63:0] new_v);
    logic [63:0] re, fe;
    re = ~old_v & new_v;
    fe = old_v & ~new_v;
    m_reg[5] = (m_reg[5] | (m_reg[3] & ((m_reg[4] & re) | (~m_reg[4] & fe)))) & PADMASK;
  endtask

  function automatic logic [NUM_IRQ-1:0] model_irq();
    logic [NUM_IRQ-1:0] r;
    r = '0;
    for (int p = 0; p < NUM_IO; p++) if (m_reg[5][p]) r[p % NUM_IRQ] = 1'b1;
    return r;
  endfunction

  // One bus access; lat = edges until ack (-1 if none within 16), ack_after = ack one cycle later.
  task automatic wb_access(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd, output int lat,
                           output logic ack_after);
    @(negedge clk);
    adr = a; we = w; sel = s; dat_i = d; cyc = 1'b1; stb = 1'b1;
    lat = -1; rd = '0; ack_after = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i;
        rd = dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (lat > 0) begin
      @(posedge clk); #1;
      ack_after = ack;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int lat;
    logic aa;
    wb_access(a, 1'b1, s, d, rd, lat, aa);
    check("wr_latency", 64'(lat), 64'd1);
    check("wr_ack_drop", 64'(aa), 64'd0);
    model_write(a, d, s);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, output logic [31:0] rd);
    int lat;
    logic aa;
    logic [31:0] exp;
    exp = model_read(a);
    wb_access(a, 1'b0, 4'hF, 32'h0, rd, lat, aa);
    check("rd_latency", 64'(lat), 64'd1);
    check(tag, 64'(rd), 64'(exp));
  endtask

  task automatic apply_io(input logic [NUM_IO-1:0] v);
    logic [63:0] old_v;
    @(negedge clk);
    old_v = 64'(io_in);
    io_in = v;
    repeat (5) @(negedge clk);
    model_event(old_v, 64'(v));
  endtask

  task automatic check_pins();
    @(posedge clk); #1;
    check("io_out", 64'(io_out), m_reg[0] & PADMASK);
    check("io_oeb", 64'(io_oeb), m_reg[1] & PADMASK);
    check("user_irq", 64'(irq), 64'(model_irq()));
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] d [6];
    logic [5:0]  ack_pat;
    logic [63:0] old_v;
    int lat;
    logic aa;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_oeb", 64'(io_oeb), PADMASK);
    check("rst_out", 64'(io_out), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_dat", 64'(dat_o), 64'd0);
    rst_n = 1'b1;

    // Reset values through the bus
    do_read("oeb_bank0", BASE + 32'h04, rd);
    check("oeb_bank0_const", 64'(rd), 64'hFFFF_FFFF);
    do_read("oeb_bank1", BASE + 32'h24, rd);
    check("oeb_bank1_const", 64'(rd), 64'h0000_003F);

    // Partial byte-enable write
    do_write(BASE, 32'hA5A5_A5A5, 4'b0011);
    check("out_sel0011", 64'(io_out), 64'h0000_A5A5);

    // Rising-edge latency to status and interrupt
    do_write(BASE + 32'h0C, 32'h20, 4'hF);
    do_write(BASE + 32'h10, 32'h20, 4'hF);
    @(negedge clk);
    old_v = 64'(io_in);
    io_in[5] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("irq_latency", 64'(irq), (k == 4) ? 64'h4 : 64'h0);
    end
    model_event(old_v, 64'(io_in));
    do_read("stat_after_rise", BASE + 32'h14, rd);
    do_write(BASE + 32'h14, 32'h20, 4'hF);
    @(posedge clk); #1;
    check("irq_after_w1c", 64'(irq), 64'd0);

    // Clear and new event on the same edge: the event wins
    apply_io(io_in & ~38'h20);
    apply_io(io_in | 38'h20);
    check_pins();
    apply_io(io_in & ~38'h20);
    @(negedge clk);
    old_v = 64'(io_in);
    io_in[5] = 1'b1;
    do_write(BASE + 32'h14, 32'h20, 4'hF);
    model_event(old_v, 64'(io_in));
    repeat (2) @(posedge clk);
    #1;
    check("irq_set_wins", 64'(irq), 64'h4);
    do_read("stat_set_wins", BASE + 32'h14, rd);
    do_write(BASE + 32'h14, 32'h20, 4'hF);
    check_pins();

    // Unmapped offsets and foreign base
    do_read("unmapped_reg6", BASE + 32'h18, rd);
    do_read("unaligned", BASE + 32'h01, rd);
    do_write(BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF);
    do_write(BASE + 32'h48, 32'hFFFF_FFFF, 4'hF);
    check_pins();
    wb_access(BASE + 32'h100, 1'b0, 4'hF, 32'h0, rd, lat, aa);
    check("base_miss_noack", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset while a write is pending commit
    @(negedge clk);
    adr = BASE; we = 1'b1; sel = 4'hF; dat_i = 32'hFFFF_FFFF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_midcycle_ack", 64'(ack), 64'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("rst_midcycle_ack2", 64'(ack), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_midcycle_out", 64'(io_out), 64'd0);
    check_pins();

    // Strobe held six cycles: ack every other cycle, one commit per ack
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        adr = BASE; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      end
      d[k] = $urandom;
      dat_i = d[k];
      ack_pat[k] = ack;
      if (k == 2) begin
        model_write(BASE, d[0], 4'hF);
        check("hold_commit0", 64'(io_out), m_reg[0]);
      end
      if (k == 4) begin
        model_write(BASE, d[2], 4'hF);
        check("hold_commit2", 64'(io_out), m_reg[0]);
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    model_write(BASE, d[4], 4'hF);
    check("hold_commit4", 64'(io_out), m_reg[0]);
    check("hold_ack_pattern", 64'(ack_pat), 64'b101010);

    // Randomised register traffic and pad activity
    for (int n = 0; n < 80; n++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 3));
      if (op == 0) begin
        apply_io(NUM_IO'({$urandom, $urandom}));
      end else begin
        a = BASE + {24'h0, 3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'b00};
        if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
        if (op == 1) do_read("rand_read", a, rd);
        else do_write(a, $urandom, 4'($urandom_range(0, 15)));
      end
      check_pins();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
